// File: rtl/msrv_pkg.sv
// Shared definitions for the msrv fetch-stage PC generator: PC-source
// encodings, PC generator FSM states and sequential step sizes.
package msrv_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'b00,
        PC_EPC  = 2'b01,
        PC_TRAP = 2'b10,
        PC_NEXT = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } pc_state_e;

    localparam int unsigned STEP_WORD = 32'd4;
    localparam int unsigned STEP_HALF = 32'd2;

    function automatic logic is_redirect(input pc_src_e src, input logic taken);
        return (src != PC_NEXT) || taken;
    endfunction

endpackage

// File: rtl/msrv_redirect_buf.sv
// One-entry redirect buffer: holds the youngest redirect seen while the
// instruction bus is stalled, together with its misaligned/trap attributes.
module msrv_redirect_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            wr,
    input  logic [XLEN-1:0] wr_target,
    input  logic            wr_misaligned,
    input  logic            wr_trap,
    output logic            valid,
    output logic [XLEN-1:0] target,
    output logic            misaligned,
    output logic            trap
);

    logic            valid_r;
    logic [XLEN-1:0] target_r;
    logic            misaligned_r;
    logic            trap_r;

    // Buffer storage; a later write overwrites the held entry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid_r      <= 1'b0;
            target_r     <= {XLEN{1'b0}};
            misaligned_r <= 1'b0;
            trap_r       <= 1'b0;
        end else if (wr) begin
            valid_r      <= 1'b1;
            target_r     <= wr_target;
            misaligned_r <= wr_misaligned;
            trap_r       <= wr_trap;
        end else begin
            valid_r      <= valid_r;
            target_r     <= target_r;
            misaligned_r <= misaligned_r;
            trap_r       <= trap_r;
        end
    end

    assign valid      = valid_r;
    assign target     = target_r;
    assign misaligned = misaligned_r;
    assign trap       = trap_r;

endmodule

// File: rtl/msrv_pc_gen.sv
// Registered program-counter generator for the msrv fetch stage: selects the
// next PC, drives the fetch address under a ready handshake, buffers stalled redirects.
module msrv_pc_gen
    import msrv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned     IALIGN       = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [1:0]      pc_src_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] iaddr_in,
    input  logic            instr_compressed_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_mux_out,
    output logic [XLEN-1:0] pc_plus_step_out,
    output logic [XLEN-1:0] imaddr_out,
    output logic            imaddr_valid_out,
    output logic            misaligned_instr_logic_out,
    output logic            redirect_pending_out
);

    pc_state_e       state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imaddr_r;
    logic            valid_r;
    logic            mis_r;

    pc_src_e         pc_src_s;
    logic [XLEN-1:0] step_s;
    logic [XLEN-1:0] plus_s;
    logic [XLEN-1:0] branch_target_s;
    logic [XLEN-1:0] mux_s;
    logic            redirect_s;
    logic            fresh_mis_s;
    logic            fresh_trap_s;
    logic            advance_s;
    logic            buf_wr_s;
    logic            buf_valid_s;
    logic [XLEN-1:0] buf_target_s;
    logic            buf_mis_s;
    logic            buf_trap_s;
    logic [XLEN-1:0] sel_addr_s;
    logic            sel_mis_s;
    logic            sel_trap_s;
    logic            unused_s;

    assign pc_src_s        = pc_src_e'(pc_src_in);
    assign branch_target_s = {iaddr_in[XLEN-1:1], 1'b0};
    assign unused_s        = iaddr_in[0];

    // Next-PC candidate, sequential step and redirect classification.
    always_comb begin
        step_s = XLEN'(STEP_WORD);
        if ((IALIGN == 32'd16) && instr_compressed_in) begin
            step_s = XLEN'(STEP_HALF);
        end else begin
            step_s = XLEN'(STEP_WORD);
        end
        plus_s = pc_r + step_s;
        mux_s  = plus_s;
        case (pc_src_s)
            PC_BOOT: mux_s = RESET_VECTOR;
            PC_EPC:  mux_s = epc_in;
            PC_TRAP: mux_s = trap_address_in;
            PC_NEXT: mux_s = branch_taken_in ? branch_target_s : plus_s;
            default: mux_s = plus_s;
        endcase
        redirect_s   = is_redirect(pc_src_s, branch_taken_in);
        fresh_mis_s  = (IALIGN == 32'd32) && (pc_src_s == PC_NEXT) &&
                       branch_taken_in && iaddr_in[1];
        fresh_trap_s = (pc_src_s == PC_TRAP);
    end

    // Advance source priority: fresh redirect, then buffered redirect, then sequential.
    always_comb begin
        advance_s  = (state_r != ST_BOOT) && ahb_ready_in;
        buf_wr_s   = (state_r != ST_BOOT) && !ahb_ready_in && redirect_s;
        sel_addr_s = mux_s;
        sel_mis_s  = 1'b0;
        sel_trap_s = 1'b0;
        if (redirect_s) begin
            sel_addr_s = mux_s;
            sel_mis_s  = fresh_mis_s;
            sel_trap_s = fresh_trap_s;
        end else if (buf_valid_s) begin
            sel_addr_s = buf_target_s;
            sel_mis_s  = buf_mis_s;
            sel_trap_s = buf_trap_s;
        end else begin
            sel_addr_s = mux_s;
            sel_mis_s  = 1'b0;
            sel_trap_s = 1'b0;
        end
    end

    msrv_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
        .clk           (clk_in),
        .rst           (rst_in),
        .clr           (advance_s),
        .wr            (buf_wr_s),
        .wr_target     (mux_s),
        .wr_misaligned (fresh_mis_s),
        .wr_trap       (fresh_trap_s),
        .valid         (buf_valid_s),
        .target        (buf_target_s),
        .misaligned    (buf_mis_s),
        .trap          (buf_trap_s)
    );

    // PC generator FSM with registered PC, fetch address, valid and misaligned pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_VECTOR;
            imaddr_r <= RESET_VECTOR;
            valid_r  <= 1'b0;
            mis_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r  <= ST_RUN;
                    imaddr_r <= RESET_VECTOR;
                    valid_r  <= 1'b1;
                    mis_r    <= 1'b0;
                end
                ST_RUN, ST_STALL: begin
                    if (ahb_ready_in) begin
                        state_r  <= ST_RUN;
                        pc_r     <= sel_addr_s;
                        imaddr_r <= sel_addr_s;
                        mis_r    <= sel_mis_s;
                        // A misaligned target suppresses fetch until a trap redirect.
                        if (sel_mis_s) begin
                            valid_r <= 1'b0;
                        end else if (sel_trap_s) begin
                            valid_r <= 1'b1;
                        end else begin
                            valid_r <= valid_r;
                        end
                    end else begin
                        state_r <= ST_STALL;
                        mis_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_BOOT;
                    pc_r     <= RESET_VECTOR;
                    imaddr_r <= RESET_VECTOR;
                    valid_r  <= 1'b0;
                    mis_r    <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out                     = pc_r;
    assign pc_mux_out                 = mux_s;
    assign pc_plus_step_out           = plus_s;
    assign imaddr_out                 = imaddr_r;
    assign imaddr_valid_out           = valid_r;
    assign misaligned_instr_logic_out = mis_r;
    assign redirect_pending_out       = buf_valid_s;

endmodule

// File: tb/tb_msrv_pc_gen.sv
// Self-checking bench for msrv_pc_gen: IALIGN=32 and IALIGN=16 instances share
// stimulus and are compared each cycle against a behavioural model.
module tb_msrv_pc_gen;

    typedef struct {
        logic [31:0] a;
        bit          mis32;
        bit          trap;
    } redir_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src = 2'b11;
    logic [31:0] epc = 32'h0;
    logic [31:0] trap_a = 32'h0;
    logic        taken = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        comp = 1'b0;
    logic        ready = 1'b1;

    logic [31:0] pc_w[2], mux_w[2], plus_w[2], ia_w[2];
    logic        v_w[2], mis_w[2], pend_w[2];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc[2], m_ia[2];
    bit          m_v[2], m_mis[2];
    bit          m_boot = 1'b0;
    bit          m_known = 1'b0;
    redir_t      m_q[$];

    always #5 clk = ~clk;

    msrv_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) u32 (
        .clk_in(clk), .rst_in(rst), .pc_src_in(src), .epc_in(epc),
        .trap_address_in(trap_a), .branch_taken_in(taken), .iaddr_in(iaddr),
        .instr_compressed_in(comp), .ahb_ready_in(ready),
        .pc_out(pc_w[0]), .pc_mux_out(mux_w[0]), .pc_plus_step_out(plus_w[0]),
        .imaddr_out(ia_w[0]), .imaddr_valid_out(v_w[0]),
        .misaligned_instr_logic_out(mis_w[0]), .redirect_pending_out(pend_w[0])
    );

    msrv_pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) u16 (
        .clk_in(clk), .rst_in(rst), .pc_src_in(src), .epc_in(epc),
        .trap_address_in(trap_a), .branch_taken_in(taken), .iaddr_in(iaddr),
        .instr_compressed_in(comp), .ahb_ready_in(ready),
        .pc_out(pc_w[1]), .pc_mux_out(mux_w[1]), .pc_plus_step_out(plus_w[1]),
        .imaddr_out(ia_w[1]), .imaddr_valid_out(v_w[1]),
        .misaligned_instr_logic_out(mis_w[1]), .redirect_pending_out(pend_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model, check registers.
    task automatic step(input bit r, input logic [1:0] s, input bit tk, input logic [31:0] ta,
                        input logic [31:0] ep, input logic [31:0] tr, input bit cp, input bit rdy);
        logic [31:0] e_plus[2];
        logic [31:0] e_mux[2];
        logic [31:0] tgt;
        bit          redir, mis32, trp, from_q;
        redir_t      sel;
        rst = r; src = s; taken = tk; iaddr = ta; epc = ep; trap_a = tr; comp = cp; ready = rdy;
        #1;
        tgt = ta & 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            e_plus[k] = m_pc[k] + ((k == 1 && cp) ? 32'd2 : 32'd4);
            case (s)
                2'b00:   e_mux[k] = 32'h0;
                2'b01:   e_mux[k] = ep;
                2'b10:   e_mux[k] = tr;
                default: e_mux[k] = tk ? tgt : e_plus[k];
            endcase
            if (m_known) begin
                chk($sformatf("plus%0d", k), plus_w[k], e_plus[k]);
                chk($sformatf("mux%0d", k), mux_w[k], e_mux[k]);
            end
        end
        @(posedge clk);
        redir = (s != 2'b11) || tk;
        mis32 = (s == 2'b11) && tk && ta[1];
        trp   = (s == 2'b10);
        if (r) begin
            m_known = 1'b1;
            m_boot  = 1'b1;
            m_q.delete();
            for (int k = 0; k < 2; k++) begin
                m_pc[k] = 32'h0; m_ia[k] = 32'h0; m_v[k] = 1'b0; m_mis[k] = 1'b0;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_ia[k] = 32'h0; m_v[k] = 1'b1; m_mis[k] = 1'b0;
            end
        end else if (rdy) begin
            from_q = (m_q.size() > 0);
            if (redir) sel = '{e_mux[0], mis32, trp};
            else if (from_q) sel = m_q[$];
            else sel = '{32'h0, 1'b0, 1'b0};
            for (int k = 0; k < 2; k++) begin
                m_pc[k]  = (redir || from_q) ? sel.a : e_plus[k];
                m_ia[k]  = m_pc[k];
                m_mis[k] = (k == 0) && sel.mis32;
                if (m_mis[k]) m_v[k] = 1'b0;
                else if (sel.trap) m_v[k] = 1'b1;
            end
            m_q.delete();
        end else begin
            m_mis[0] = 1'b0; m_mis[1] = 1'b0;
            if (redir) m_q.push_back('{e_mux[0], mis32, trp});
        end
        #1;
        if (m_known) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("pc%0d", k), pc_w[k], m_pc[k]);
                chk($sformatf("imaddr%0d", k), ia_w[k], m_ia[k]);
                chk($sformatf("valid%0d", k), {31'h0, v_w[k]}, {31'h0, m_v[k]});
                chk($sformatf("mis%0d", k), {31'h0, mis_w[k]}, {31'h0, m_mis[k]});
                chk($sformatf("pend%0d", k), {31'h0, pend_w[k]}, {31'h0, (m_q.size() > 0)});
            end
        end
    endtask

    task automatic seq(input bit rdy);
        step(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic br(input logic [31:0] t, input bit rdy);
        step(1'b0, 2'b11, 1'b1, t, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    initial begin
        m_pc[0] = 32'h0; m_pc[1] = 32'h0; m_ia[0] = 32'h0; m_ia[1] = 32'h0;
        m_v[0] = 1'b0; m_v[1] = 1'b0; m_mis[0] = 1'b0; m_mis[1] = 1'b0;

        // Reset and release.
        step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("rst_valid", {31'h0, v_w[0]}, 32'h0);
        chk("rst_pc", pc_w[0], 32'h0);
        seq(1'b1);
        chk("boot_valid", {31'h0, v_w[0]}, 32'h1);
        chk("boot_imaddr", ia_w[0], 32'h0);
        seq(1'b1); seq(1'b1); seq(1'b1);
        chk("seq_pc_c", pc_w[0], 32'hC);

        // Stalled jump.
        br(32'h100, 1'b1);
        br(32'h200, 1'b0);
        chk("stall_pending", {31'h0, pend_w[0]}, 32'h1);
        seq(1'b0); seq(1'b0);
        chk("stall_hold_pc", pc_w[0], 32'h100);
        seq(1'b1);
        chk("stall_pc", pc_w[0], 32'h200);
        chk("stall_imaddr", ia_w[0], 32'h200);
        chk("stall_cleared", {31'h0, pend_w[0]}, 32'h0);

        // Overwrite within a stall.
        br(32'h300, 1'b0);
        step(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h80, 1'b0, 1'b0);
        seq(1'b1);
        chk("overwrite_pc", pc_w[0], 32'h80);

        // Misaligned target, then trap restores valid.
        br(32'h402, 1'b1);
        chk("mis_pulse", {31'h0, mis_w[0]}, 32'h1);
        chk("mis_pc", pc_w[0], 32'h402);
        chk("mis_valid", {31'h0, v_w[0]}, 32'h0);
        chk("mis16_none", {31'h0, mis_w[1]}, 32'h0);
        seq(1'b1);
        chk("mis_pulse_end", {31'h0, mis_w[0]}, 32'h0);
        step(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h80, 1'b0, 1'b1);
        chk("trap_valid", {31'h0, v_w[0]}, 32'h1);

        // Compressed step on the IALIGN=16 instance.
        br(32'h10, 1'b1);
        step(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("comp_pc", pc_w[1], 32'h12);
        br(32'h15, 1'b1);
        chk("comp_tgt", pc_w[1], 32'h14);
        chk("comp_nomis", {31'h0, mis_w[1]}, 32'h0);

        // Wrap-around.
        step(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        br(32'hFFFF_FFFC, 1'b1);
        seq(1'b1);
        chk("wrap_pc", pc_w[0], 32'h0);

        // Reset mid-stall discards the buffer.
        br(32'h500, 1'b0);
        step(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_pend", {31'h0, pend_w[0]}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int       sr;
            logic [1:0] s;
            sr = $urandom_range(0, 15);
            s  = (sr < 3) ? sr[1:0] : 2'b11;
            step($urandom_range(0, 99) == 0, s, $urandom_range(0, 3) == 0, $urandom,
                 $urandom, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
